fg_prog_sequencer: RTL and testbench



---
 rtl/fg_prog_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: selects one cell, then alternates ADC measurements and
// drain pulses until the code reaches target, the pulse budget runs out, the ADC stalls or abort.
module fg_prog_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned ADC_W       = 14,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned PULSE_CYC   = 32,
    parameter int unsigned ADC_TIMEOUT = 255
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_row,
    input  logic [ADDR_W-1:0] cmd_col,
    input  logic [ADC_W-1:0]  cmd_target,
    input  logic [7:0]        cmd_max_pulses,
    input  logic              abort,
    output logic              sel_en,
    output logic [ADDR_W-1:0] sel_row,
    output logic [ADDR_W-1:0] sel_col,
    output logic              drain_pulse,
    output logic              adc_start,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_code,
    output logic              busy,
    output logic              done,
    output logic [1:0]        done_status,
    output logic [7:0]        done_pulses,
    output logic [ADC_W-1:0]  done_code
);

    localparam int unsigned CNT_MAX0 = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > ADC_TIMEOUT) ? CNT_MAX0 : ADC_TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ADC_TIMEOUT - 1);

    localparam logic [1:0] StatReached = 2'b00;
    localparam logic [1:0] StatBudget  = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;
    localparam logic [1:0] StatAborted = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StMeasure,
        StCompare,
        StPulse,
        StSettle,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        pulse_cnt_q, pulse_cnt_d;
    logic [ADC_W-1:0]  code_q, code_d;
    logic [ADC_W-1:0]  target_q;
    logic [7:0]        max_q;
    logic [1:0]        status_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        code_d      = code_q;
        status_d    = StatReached;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d     = StSelect;
                    cnt_d       = '0;
                    pulse_cnt_d = '0;
                    code_d      = '0;
                end
            end
            StSelect, StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StMeasure;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMeasure: begin
                // The strobe cycle itself never counts as a reply.
                if (cnt_q != '0 && adc_valid) begin
                    state_d = StCompare;
                    code_d  = adc_code;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d  = StDone;
                    status_d = StatTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompare: begin
                if (code_q <= target_q) begin
                    state_d  = StDone;
                    status_d = StatReached;
                end else if (pulse_cnt_q == max_q) begin
                    state_d  = StDone;
                    status_d = StatBudget;
                end else begin
                    state_d = StPulse;
                    cnt_d   = '0;
                end
            end
            StPulse: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d     = StSettle;
                    cnt_d       = '0;
                    pulse_cnt_d = pulse_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort overrides everything in the active states, including a same-cycle ADC reply.
        if (abort && state_q != StIdle && state_q != StDone) begin
            state_d     = StDone;
            status_d    = StatAborted;
            code_d      = code_q;
            pulse_cnt_d = pulse_cnt_q;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_cnt_q <= '0;
            code_q      <= '0;
            target_q    <= '0;
            max_q       <= '0;
            sel_row     <= '0;
            sel_col     <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            sel_en      <= 1'b0;
            drain_pulse <= 1'b0;
            adc_start   <= 1'b0;
            done        <= 1'b0;
            done_status <= '0;
            done_pulses <= '0;
            done_code   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            code_q      <= code_d;
            if (state_q == StIdle && cmd_valid) begin
                sel_row  <= cmd_row;
                sel_col  <= cmd_col;
                target_q <= cmd_target;
                max_q    <= cmd_max_pulses;
            end
            // Outputs are decoded from the next state so they line up with state_q.
            cmd_ready   <= (state_d == StIdle);
            busy        <= (state_d != StIdle);
            sel_en      <= state_d inside {StSelect, StMeasure, StCompare, StPulse, StSettle};
            drain_pulse <= (state_d == StPulse);
            adc_start   <= (state_d == StMeasure) && (state_q != StMeasure);
            done        <= (state_d == StDone);
            done_status <= (state_d == StDone) ? status_d : 2'b00;
            done_pulses <= (state_d == StDone) ? pulse_cnt_d : 8'd0;
            done_code   <= (state_d == StDone) ? code_d : '0;
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Self-checking bench for fg_prog_sequencer: directed scenarios plus randomized commands
// checked against a timeline model of the measure/pulse loop.
module tb_fg_prog_sequencer;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned ADC_W       = 14;
    localparam int unsigned SETTLE_CYC  = 16;
    localparam int unsigned PULSE_CYC   = 32;
    localparam int unsigned ADC_TIMEOUT = 255;

    logic              mclk           = 1'b0;
    logic              rst            = 1'b1;
    logic              cmd_valid      = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_row        = '0;
    logic [ADDR_W-1:0] cmd_col        = '0;
    logic [ADC_W-1:0]  cmd_target     = '0;
    logic [7:0]        cmd_max_pulses = '0;
    logic              abort          = 1'b0;
    logic              sel_en;
    logic [ADDR_W-1:0] sel_row, sel_col;
    logic              drain_pulse, adc_start;
    logic              adc_valid      = 1'b0;
    logic [ADC_W-1:0]  adc_code       = '0;
    logic              busy, done;
    logic [1:0]        done_status;
    logic [7:0]        done_pulses;
    logic [ADC_W-1:0]  done_code;

    int checks = 0;
    int errors = 0;

    fg_prog_sequencer #(
        .ADDR_W(ADDR_W), .ADC_W(ADC_W), .SETTLE_CYC(SETTLE_CYC),
        .PULSE_CYC(PULSE_CYC), .ADC_TIMEOUT(ADC_TIMEOUT)
    ) dut (
        .mclk(mclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_target(cmd_target),
        .cmd_max_pulses(cmd_max_pulses), .abort(abort), .sel_en(sel_en), .sel_row(sel_row),
        .sel_col(sel_col), .drain_pulse(drain_pulse), .adc_start(adc_start),
        .adc_valid(adc_valid), .adc_code(adc_code), .busy(busy), .done(done),
        .done_status(done_status), .done_pulses(done_pulses), .done_code(done_code)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    // ADC responder: each adc_start pops one (latency, code); latency 0 means no reply.
    int unsigned      rsp_lat[$];
    logic [ADC_W-1:0] rsp_code[$];
    int unsigned      adc_cd   = 0;
    logic [ADC_W-1:0] adc_pend = '0;

    always @(negedge mclk) begin
        adc_valid = 1'b0;
        if (rst || done) begin
            adc_cd = 0;
            rsp_lat.delete();
            rsp_code.delete();
        end else if (adc_start) begin
            adc_cd = 0;
            if (rsp_lat.size() > 0) begin
                adc_cd   = rsp_lat.pop_front();
                adc_pend = rsp_code.pop_front();
            end
        end else if (adc_cd > 0) begin
            adc_cd = adc_cd - 1;
            if (adc_cd == 0) begin
                adc_valid = 1'b1;
                adc_code  = adc_pend;
            end
        end
    end

    // Observation of pulse run lengths, select stability, strobes and completions.
    int unsigned       runs[$];
    int unsigned       run_len   = 0;
    int                sel_bad   = 0;
    int                start_cnt = 0;
    int                start_cyc = 0;
    int                done_cnt  = 0;
    int                done_cyc  = 0;
    logic [ADDR_W-1:0] exp_row   = '0;
    logic [ADDR_W-1:0] exp_col   = '0;

    always @(negedge mclk) begin
        if (drain_pulse) begin
            run_len++;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (sel_en && (sel_row !== exp_row || sel_col !== exp_col)) sel_bad++;
        if (adc_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Timeline model: cycle numbers are relative to the accept edge (first SELECT cycle = 1).
    function automatic void model(input int unsigned tgt, input int unsigned mx,
                                  input int unsigned lat[$], input int unsigned cod[$],
                                  output int unsigned st, output int unsigned np,
                                  output int unsigned cd, output int unsigned at);
        int unsigned t;
        t  = SETTLE_CYC + 1;
        np = 0;
        cd = 0;
        st = 0;
        at = 0;
        for (int k = 0; k < 300; k++) begin
            if (k >= lat.size() || lat[k] == 0 || lat[k] >= ADC_TIMEOUT) begin
                st = 2;
                at = t + ADC_TIMEOUT;
                return;
            end
            cd = cod[k];
            t  = t + lat[k];
            if (cd <= tgt) begin
                st = 0;
                at = t + 2;
                return;
            end
            if (np == mx) begin
                st = 1;
                at = t + 2;
                return;
            end
            np++;
            t = t + 2 + PULSE_CYC + SETTLE_CYC;
        end
    endfunction

    task automatic tick();
        @(negedge mclk);
        #1;
    endtask

    task automatic push_rsp(input int unsigned lat, input int unsigned code);
        rsp_lat.push_back(lat);
        rsp_code.push_back(ADC_W'(code));
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col,
                             input logic [ADC_W-1:0] tgt, input logic [7:0] mx, output int c0);
        for (int i = 0; i < 1000 && !cmd_ready; i++) tick();
        exp_row        = row;
        exp_col        = col;
        cmd_row        = row;
        cmd_col        = col;
        cmd_target     = tgt;
        cmd_max_pulses = mx;
        cmd_valid      = 1'b1;
        tick();
        c0        = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name, input int c0, output int rel);
        bit ok;
        ok  = 1'b0;
        rel = -1;
        for (int i = 0; i < 5000; i++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done_wait: got no done, want done within 5000 cycles", name);
        end else begin
            rel = done_cyc - c0 + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, busy, sel_en, drain_pulse, adc_start, done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset flags: got %b want 100000",
                     {cmd_ready, busy, sel_en, drain_pulse, adc_start, done});
        end
        checks++;
        if ({done_status, done_pulses, done_code, sel_row, sel_col} !== '0) begin
            errors++;
            $display("FAIL reset data: got %h want 0",
                     {done_status, done_pulses, done_code, sel_row, sel_col});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_at_target();
        int c0, rel, d0, r0;
        push_rsp(3, 100);
        d0 = done_cnt;
        r0 = runs.size();
        start_cmd(8'h12, 8'h34, 14'd200, 8'd10, c0);
        wait_done(d0, "at_target", c0, rel);
        checks++;
        if (rel != 22) begin errors++; $display("FAIL at_target cycle: got %0d want 22", rel); end
        checks++;
        if ({done_status, done_pulses, done_code} !== {2'd0, 8'd0, 14'd100}) begin
            errors++;
            $display("FAIL at_target result: got st=%0d p=%0d c=%0d want 0/0/100",
                     done_status, done_pulses, done_code);
        end
        checks++;
        if (runs.size() != r0 || run_len != 0) begin
            errors++;
            $display("FAIL at_target drain: got %0d runs want 0", runs.size() - r0);
        end
    endtask

    task automatic test_converging();
        int c0, rel, d0, r0, sb, bad;
        push_rsp(3, 900); push_rsp(3, 700); push_rsp(3, 500); push_rsp(3, 300);
        d0  = done_cnt;
        r0  = runs.size();
        sb  = sel_bad;
        bad = 0;
        start_cmd(8'hA5, 8'h5A, 14'd400, 8'd10, c0);
        wait_done(d0, "converge", c0, rel);
        checks++;
        if (rel != 22 + 3 * 53) begin
            errors++;
            $display("FAIL converge cycle: got %0d want %0d", rel, 22 + 3 * 53);
        end
        checks++;
        if ({done_status, done_pulses, done_code} !== {2'd0, 8'd3, 14'd300}) begin
            errors++;
            $display("FAIL converge result: got st=%0d p=%0d c=%0d want 0/3/300",
                     done_status, done_pulses, done_code);
        end
        for (int i = r0; i < runs.size(); i++) if (runs[i] != PULSE_CYC) bad++;
        checks++;
        if (runs.size() - r0 != 3 || bad != 0) begin
            errors++;
            $display("FAIL converge pulses: got %0d runs (%0d wrong length) want 3 of 32",
                     runs.size() - r0, bad);
        end
        checks++;
        if (sel_bad != sb) begin
            errors++;
            $display("FAIL converge select: got %0d unstable cycles want 0", sel_bad - sb);
        end
    endtask

    task automatic test_budget();
        int c0, rel, d0, s0;
        push_rsp(3, 900); push_rsp(3, 900); push_rsp(3, 900);
        d0 = done_cnt;
        start_cmd(8'h01, 8'h02, 14'd400, 8'd2, c0);
        wait_done(d0, "budget2", c0, rel);
        checks++;
        if (rel != 22 + 2 * 53 || {done_status, done_pulses, done_code} !== {2'd1, 8'd2, 14'd900})
        begin
            errors++;
            $display("FAIL budget2 result: got cyc=%0d st=%0d p=%0d c=%0d want %0d/1/2/900",
                     rel, done_status, done_pulses, done_code, 22 + 2 * 53);
        end
        tick();
        push_rsp(3, 900);
        d0 = done_cnt;
        s0 = start_cnt;
        start_cmd(8'h03, 8'h04, 14'd400, 8'd0, c0);
        wait_done(d0, "budget0", c0, rel);
        checks++;
        if (rel != 22 || {done_status, done_pulses, done_code} !== {2'd1, 8'd0, 14'd900}) begin
            errors++;
            $display("FAIL budget0 result: got cyc=%0d st=%0d p=%0d c=%0d want 22/1/0/900",
                     rel, done_status, done_pulses, done_code);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL budget0 measures: got %0d want 1", start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int c0, rel, d0;
        d0 = done_cnt;
        start_cmd(8'h10, 8'h20, 14'd400, 8'd5, c0);
        wait_done(d0, "timeout", c0, rel);
        checks++;
        if (done_cyc - start_cyc != int'(ADC_TIMEOUT)) begin
            errors++;
            $display("FAIL timeout latency: got %0d want %0d", done_cyc - start_cyc, ADC_TIMEOUT);
        end
        checks++;
        if ({done_status, done_pulses, done_code} !== {2'd2, 8'd0, 14'd0}) begin
            errors++;
            $display("FAIL timeout result: got st=%0d p=%0d c=%0d want 2/0/0",
                     done_status, done_pulses, done_code);
        end
        tick();
        push_rsp(ADC_TIMEOUT - 1, 50);
        d0 = done_cnt;
        start_cmd(8'h10, 8'h20, 14'd400, 8'd5, c0);
        wait_done(d0, "late_valid", c0, rel);
        checks++;
        if (rel != 17 + 254 + 2 || done_status !== 2'd0 || done_code !== 14'd50) begin
            errors++;
            $display("FAIL late_valid result: got cyc=%0d st=%0d c=%0d want %0d/0/50",
                     rel, done_status, done_code, 17 + 254 + 2);
        end
    endtask

    task automatic test_abort();
        int c0, rel, d0, s0;
        bit ok;
        // Abort on cycle 10 of the second pulse.
        push_rsp(3, 900); push_rsp(3, 800);
        s0 = start_cnt;
        start_cmd(8'h44, 8'h55, 14'd400, 8'd5, c0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (start_cnt - s0 >= 2 && drain_pulse) begin ok = 1'b1; break; end
            tick();
        end
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (!ok || drain_pulse !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse timing: got reached=%0d drain=%b done=%b want 1/0/1",
                     ok, drain_pulse, done);
        end
        checks++;
        if ({done_status, done_pulses, done_code} !== {2'd3, 8'd1, 14'd800}) begin
            errors++;
            $display("FAIL abort_pulse result: got st=%0d p=%0d c=%0d want 3/1/800",
                     done_status, done_pulses, done_code);
        end
        checks++;
        if (runs.size() == 0 || runs[runs.size()-1] != 10) begin
            errors++;
            $display("FAIL abort_pulse run: got %0d want 10",
                     runs.size() == 0 ? 0 : runs[runs.size()-1]);
        end
        // Abort coincident with the ADC reply.
        tick();
        push_rsp(3, 100);
        s0 = start_cnt;
        start_cmd(8'h66, 8'h77, 14'd400, 8'd5, c0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (start_cnt != s0) begin ok = 1'b1; break; end
            tick();
        end
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (!ok || done !== 1'b1 || done_status !== 2'd3) begin
            errors++;
            $display("FAIL abort_valid: got reached=%0d done=%b st=%0d want 1/1/3",
                     ok, done, done_status);
        end
        // Abort while idle is ignored.
        tick();
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, cmd_ready, done} !== 3'b010) begin
                errors++;
                $display("FAIL abort_idle: got busy/ready/done=%b want 010",
                         {busy, cmd_ready, done});
            end
        end
        abort = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int c0, rel, d0, s0;
        bit ok;
        // Reset in the middle of SETTLE.
        push_rsp(3, 900); push_rsp(3, 900);
        start_cmd(8'h21, 8'h43, 14'd400, 8'd5, c0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (drain_pulse) begin ok = 1'b1; break; end
            tick();
        end
        for (int i = 0; i < 200 && drain_pulse; i++) tick();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (!ok || {cmd_ready, busy, sel_en, drain_pulse, adc_start, done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_settle flags: got reached=%0d flags=%b want 1/100000",
                     ok, {cmd_ready, busy, sel_en, drain_pulse, adc_start, done});
        end
        rst = 1'b0;
        tick();
        // cmd_valid held while busy is taken only in the IDLE cycle after DONE.
        push_rsp(3, 100);
        d0 = done_cnt;
        s0 = start_cnt;
        start_cmd(8'h11, 8'h11, 14'd400, 8'd5, c0);
        cmd_row   = 8'h22;
        cmd_col   = 8'h33;
        cmd_valid = 1'b1;
        wait_done(d0, "held_first", c0, rel);
        checks++;
        if (rel != 22 || start_cnt - s0 != 1 || done_code !== 14'd100) begin
            errors++;
            $display("FAIL held_first: got cyc=%0d starts=%0d c=%0d want 22/1/100",
                     rel, start_cnt - s0, done_code);
        end
        d0 = done_cnt;
        push_rsp(3, 50);
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        exp_row = 8'h22;
        exp_col = 8'h33;
        tick();
        c0        = cyc;
        cmd_valid = 1'b0;
        checks++;
        if ({busy, sel_en, sel_row, sel_col} !== {2'b11, 8'h22, 8'h33}) begin
            errors++;
            $display("FAIL held_accept: got busy=%b sel=%b row=%h col=%h want 1/1/22/33",
                     busy, sel_en, sel_row, sel_col);
        end
        wait_done(d0, "held_second", c0, rel);
        checks++;
        if (rel != 22 || done_code !== 14'd50) begin
            errors++;
            $display("FAIL held_second: got cyc=%0d c=%0d want 22/50", rel, done_code);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int unsigned lat[$];
            int unsigned cod[$];
            int unsigned mx, tgt, v, st, np, cd, at;
            int c0, rel, d0, r0, sb, bad;
            lat.delete();
            cod.delete();
            mx = $urandom_range(0, 4);
            v  = $urandom_range(2000, 16383);
            for (int k = 0; k <= int'(mx); k++) begin
                lat.push_back(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6));
                cod.push_back(v);
                v = (v > 1500) ? v - $urandom_range(0, 1500) : 0;
            end
            case ($urandom_range(0, 2))
                0:       tgt = $urandom_range(0, 16383);
                1:       tgt = cod[$urandom_range(0, mx)];
                default: tgt = 0;
            endcase
            for (int k = 0; k < lat.size(); k++) push_rsp(lat[k], cod[k]);
            model(tgt, mx, lat, cod, st, np, cd, at);
            d0  = done_cnt;
            r0  = runs.size();
            sb  = sel_bad;
            bad = 0;
            start_cmd(ADDR_W'($urandom), ADDR_W'($urandom), ADC_W'(tgt), 8'(mx), c0);
            wait_done(d0, "random", c0, rel);
            checks++;
            if (rel != int'(at)) begin
                errors++;
                $display("FAIL random[%0d] cycle: got %0d want %0d", n, rel, at);
            end
            checks++;
            if ({done_status, done_pulses, done_code} !== {2'(st), 8'(np), ADC_W'(cd)}) begin
                errors++;
                $display("FAIL random[%0d] result: got st=%0d p=%0d c=%0d want %0d/%0d/%0d",
                         n, done_status, done_pulses, done_code, st, np, cd);
            end
            for (int i = r0; i < runs.size(); i++) if (runs[i] != PULSE_CYC) bad++;
            checks++;
            if (runs.size() - r0 != int'(np) || bad != 0 || sel_bad != sb) begin
                errors++;
                $display("FAIL random[%0d] activity: got runs=%0d bad=%0d sel=%0d want %0d/0/0",
                         n, runs.size() - r0, bad, sel_bad - sb, np);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_at_target();
        test_converging();
        test_budget();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
